// File: rtl/irq_pc_sequencer.sv
// irq_pc_sequencer: program-counter sequencer with edge-detected interrupts,
// an interrupt mask, illegal-instruction trapping and a kernel-mode PC bit.
// The PC register is the only state that moves with stall_i. Edge detection,
// pending flags and the mask run every cycle, so an interrupt raised during a
// stall is remembered and taken on the first unstalled user-mode cycle.
// All decisions (take interrupt / illop, epc, irq id) are combinational from
// current state and inputs; the resulting PC is loaded at the next edge.
module irq_pc_sequencer #(
    parameter int                 NUM_IRQ   = 4,
    parameter logic [31:0]        RESET_VEC = 32'h00000000,
    parameter logic [31:0]        ILLOP_VEC = 32'h80000004,
    parameter logic [31:0]        XADR_VEC  = 32'h80000008,
    parameter logic [NUM_IRQ-1:0] MASK_RST  = '1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic [2:0]         pcsrc_i,
    input  logic               branch_taken_i,
    input  logic [31:0]        branch_tgt_i,
    input  logic [25:0]        jidx_i,
    input  logic [31:0]        jr_tgt_i,
    input  logic               illop_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               mask_we_i,
    input  logic [NUM_IRQ-1:0] mask_d_i,
    output logic [31:0]        pc_o,
    output logic [31:0]        pc4_o,
    output logic [31:0]        epc_o,
    output logic               epc_we_o,
    output logic               kernel_o,
    output logic [NUM_IRQ-1:0] pend_o,
    output logic [3:0]         irq_id_o,
    output logic               kerr_o
);

    logic [31:0]        r_pc;
    logic [NUM_IRQ-1:0] r_pend;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_irq_prev;
    logic               r_kerr;

    logic [31:0]        w_pc4;
    logic               w_kernel;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_masked;
    logic [NUM_IRQ-1:0] w_sel;
    logic [NUM_IRQ-1:0] w_clr;
    logic [3:0]         w_irq_id;
    logic               w_take_irq;
    logic               w_take_ill;
    logic [31:0]        w_normal_pc;
    logic [31:0]        w_next_pc;

    // Bit 31 is the kernel flag; only the low 31 bits advance and wrap.
    assign w_pc4    = {r_pc[31], r_pc[30:0] + 31'd4};
    assign w_kernel = r_pc[31];
    assign w_rise   = irq_i & ~r_irq_prev;
    assign w_masked = r_pend & r_mask;

    // Lowest set index of the masked pending vector, as an id and a one-hot.
    always_comb begin
        w_irq_id = 4'd0;
        w_sel    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_irq_id = 4'(i);
                w_sel    = '0;
                w_sel[i] = 1'b1;
            end
        end
    end

    // Events are suppressed while in reset, stalled, or in kernel mode.
    assign w_take_irq = ~reset & ~stall_i & ~w_kernel & (|w_masked);
    assign w_take_ill = ~reset & ~stall_i & ~w_kernel & illop_i & ~w_take_irq;
    assign w_clr      = w_take_irq ? w_sel : '0;

    // Normal next-PC selection from the decoded pcsrc code.
    always_comb begin
        w_normal_pc = RESET_VEC;
        case (pcsrc_i)
            3'b000:  w_normal_pc = w_pc4;
            3'b001:  w_normal_pc = branch_taken_i ? branch_tgt_i : w_pc4;
            3'b010:  w_normal_pc = {r_pc[31:28], jidx_i, 2'b00};
            3'b011:  w_normal_pc = jr_tgt_i;
            default: w_normal_pc = RESET_VEC;
        endcase
    end

    // Interrupts outrank illegal-instruction traps.
    always_comb begin
        w_next_pc = w_normal_pc;
        if (w_take_irq) begin
            w_next_pc = XADR_VEC;
        end else if (w_take_ill) begin
            w_next_pc = ILLOP_VEC;
        end
    end

    // PC advances only when not stalled; kernel-mode illop sets the sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc   <= RESET_VEC;
            r_kerr <= 1'b0;
        end else if (!stall_i) begin
            r_pc <= w_next_pc;
            if (w_kernel && illop_i) begin
                r_kerr <= 1'b1;
            end
        end
    end

    // Edge history, pending flags and mask update every cycle regardless of stall;
    // a new edge wins over a clear of the same bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_prev <= '0;
            r_pend     <= '0;
            r_mask     <= MASK_RST;
        end else begin
            r_irq_prev <= irq_i;
            r_pend     <= (r_pend & ~w_clr) | w_rise;
            if (mask_we_i) begin
                r_mask <= mask_d_i;
            end
        end
    end

    // Interrupt return re-executes the interrupted instruction; illop skips it.
    assign epc_o    = w_take_irq ? r_pc : w_pc4;
    assign epc_we_o = w_take_irq | w_take_ill;
    assign irq_id_o = w_take_irq ? w_irq_id : 4'd0;
    assign pc_o     = r_pc;
    assign pc4_o    = w_pc4;
    assign kernel_o = w_kernel;
    assign pend_o   = r_pend;
    assign kerr_o   = r_kerr;

endmodule

// File: tb/tb_irq_pc_sequencer.sv
// tb_irq_pc_sequencer: table-driven bench for irq_pc_sequencer. Each table row
// holds the inputs for one cycle and the outputs expected during that cycle.
// Inputs are driven on the falling edge; expectations go into a queue and are
// popped and compared a little later, before the next rising edge.
module tb_irq_pc_sequencer;

    localparam int W = 74;

    typedef struct {
        logic        stall;
        logic [2:0]  pcsrc;
        logic        bt;
        logic [31:0] tgt;
        logic        illop;
        logic [3:0]  irq;
        logic        mwe;
        logic [3:0]  md;
        logic [31:0] e_pc;
        logic        e_we;
        logic [31:0] e_epc;
        logic [3:0]  e_id;
        logic [3:0]  e_pend;
        logic        e_kerr;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic [2:0]  pcsrc_i;
    logic        branch_taken_i;
    logic [31:0] branch_tgt_i;
    logic [25:0] jidx_i;
    logic [31:0] jr_tgt_i;
    logic        illop_i;
    logic [3:0]  irq_i;
    logic        mask_we_i;
    logic [3:0]  mask_d_i;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;
    logic [31:0] epc_o;
    logic        epc_we_o;
    logic        kernel_o;
    logic [3:0]  pend_o;
    logic [3:0]  irq_id_o;
    logic        kerr_o;

    logic [W-1:0] exp_q[$];
    vec_t         vecs[$];
    int           checks;
    int           errors;

    irq_pc_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .stall_i        (stall_i),
        .pcsrc_i        (pcsrc_i),
        .branch_taken_i (branch_taken_i),
        .branch_tgt_i   (branch_tgt_i),
        .jidx_i         (jidx_i),
        .jr_tgt_i       (jr_tgt_i),
        .illop_i        (illop_i),
        .irq_i          (irq_i),
        .mask_we_i      (mask_we_i),
        .mask_d_i       (mask_d_i),
        .pc_o           (pc_o),
        .pc4_o          (pc4_o),
        .epc_o          (epc_o),
        .epc_we_o       (epc_we_o),
        .kernel_o       (kernel_o),
        .pend_o         (pend_o),
        .irq_id_o       (irq_id_o),
        .kerr_o         (kerr_o)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic stall, input logic [2:0] pcsrc, input logic bt,
                       input logic [31:0] tgt, input logic illop, input logic [3:0] irq,
                       input logic mwe, input logic [3:0] md,
                       input logic [31:0] e_pc, input logic e_we, input logic [31:0] e_epc,
                       input logic [3:0] e_id, input logic [3:0] e_pend, input logic e_kerr);
        vec_t v;
        v.stall = stall; v.pcsrc = pcsrc; v.bt = bt; v.tgt = tgt; v.illop = illop;
        v.irq = irq; v.mwe = mwe; v.md = md; v.e_pc = e_pc; v.e_we = e_we;
        v.e_epc = e_epc; v.e_id = e_id; v.e_pend = e_pend; v.e_kerr = e_kerr;
        vecs.push_back(v);
    endtask

    // Driver: apply one row's inputs and queue its expected outputs.
    task automatic drive(input vec_t v);
        logic [31:0] t;
        t              = v.tgt;
        stall_i        = v.stall;
        pcsrc_i        = v.pcsrc;
        branch_taken_i = v.bt;
        branch_tgt_i   = t;
        jr_tgt_i       = t;
        jidx_i         = t[27:2];
        illop_i        = v.illop;
        irq_i          = v.irq;
        mask_we_i      = v.mwe;
        mask_d_i       = v.md;
        exp_q.push_back({v.e_pc, v.e_we, v.e_epc, v.e_id, v.e_pend, v.e_kerr});
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic we, input logic [31:0] epc,
                            input logic [3:0] id, input logic [3:0] pend, input logic kerr);
        exp_q.push_back({pc, we, epc, id, pend, kerr});
    endtask

    // Scoreboard: pop the oldest expectation and compare against the DUT.
    task automatic sample(input string name);
        logic [W-1:0] e;
        logic [W-1:0] a;
        a = {pc_o, epc_we_o, (epc_we_o ? epc_o : 32'h0), irq_id_o, pend_o, kerr_o};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: no expectation queued", name);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got pc=%h we=%b epc=%h id=%0d pend=%b kerr=%b, expected pc=%h we=%b epc=%h id=%0d pend=%b kerr=%b",
                         name, a[73:42], a[41], a[40:9], a[8:5], a[4:1], a[0],
                         e[73:42], e[41], e[40:9], e[8:5], e[4:1], e[0]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        stall_i = 1'b0; pcsrc_i = 3'b000; branch_taken_i = 1'b0; branch_tgt_i = 32'h0;
        jidx_i = 26'h0; jr_tgt_i = 32'h0; illop_i = 1'b0; irq_i = 4'b0;
        mask_we_i = 1'b0; mask_d_i = 4'b0;

        //  stall pcsrc bt tgt           ill irq     mwe md      e_pc          we epc           id pend    kerr
        // sequential fetch from reset, branch, jump, jr, wrap of bits [30:0]
        add(0, 3'b000, 0, 32'h0,         0, 4'b0000, 0, 4'b0000, 32'h00000000, 0, 32'h0,       0, 4'b0000, 0);
        add(0, 3'b000, 0, 32'h0,         0, 4'b0000, 0, 4'b0000, 32'h00000004, 0, 32'h0,       0, 4'b0000, 0);
        add(0, 3'b000, 0, 32'h0,         0, 4'b0000, 0, 4'b0000, 32'h00000008, 0, 32'h0,       0, 4'b0000, 0);
        add(0, 3'b000, 0, 32'h0,         0, 4'b0000, 0, 4'b0000, 32'h0000000C, 0, 32'h0,       0, 4'b0000, 0);
        add(0, 3'b001, 0, 32'h100,       0, 4'b0000, 0, 4'b0000, 32'h00000010, 0, 32'h0,       0, 4'b0000, 0);
        add(0, 3'b001, 1, 32'h100,       0, 4'b0000, 0, 4'b0000, 32'h00000014, 0, 32'h0,       0, 4'b0000, 0);
        add(0, 3'b010, 0, 32'h00ABCDE0,  0, 4'b0000, 0, 4'b0000, 32'h00000100, 0, 32'h0,       0, 4'b0000, 0);
        add(0, 3'b011, 0, 32'h7FFFFFFC,  0, 4'b0000, 0, 4'b0000, 32'h00ABCDE0, 0, 32'h0,       0, 4'b0000, 0);
        add(0, 3'b000, 0, 32'h0,         0, 4'b0000, 0, 4'b0000, 32'h7FFFFFFC, 0, 32'h0,       0, 4'b0000, 0);
        add(0, 3'b111, 0, 32'h0,         0, 4'b0000, 0, 4'b0000, 32'h00000000, 0, 32'h0,       0, 4'b0000, 0);
        add(0, 3'b011, 0, 32'hFFFFFFFC,  0, 4'b0000, 0, 4'b0000, 32'h00000000, 0, 32'h0,       0, 4'b0000, 0);
        add(0, 3'b000, 0, 32'h0,         0, 4'b0000, 0, 4'b0000, 32'hFFFFFFFC, 0, 32'h0,       0, 4'b0000, 0);
        add(0, 3'b011, 0, 32'h3C,        0, 4'b0000, 0, 4'b0000, 32'h80000000, 0, 32'h0,       0, 4'b0000, 0);
        // two edges at once, lowest taken first, the other after returning to user
        add(0, 3'b000, 0, 32'h0,         0, 4'b1010, 0, 4'b0000, 32'h0000003C, 0, 32'h0,       0, 4'b0000, 0);
        add(0, 3'b000, 0, 32'h0,         0, 4'b1010, 0, 4'b0000, 32'h00000040, 1, 32'h40,      1, 4'b1010, 0);
        add(0, 3'b011, 0, 32'h40,        0, 4'b1010, 0, 4'b0000, 32'h80000008, 0, 32'h0,       0, 4'b1000, 0);
        add(0, 3'b000, 0, 32'h0,         0, 4'b1010, 0, 4'b0000, 32'h00000040, 1, 32'h40,      3, 4'b1000, 0);
        add(0, 3'b011, 0, 32'h20,        0, 4'b0001, 0, 4'b0000, 32'h80000008, 0, 32'h0,       0, 4'b0000, 0);
        // illop together with an interrupt, then illop alone
        add(0, 3'b000, 0, 32'h0,         1, 4'b0001, 0, 4'b0000, 32'h00000020, 1, 32'h20,      0, 4'b0001, 0);
        add(0, 3'b011, 0, 32'h20,        0, 4'b0001, 0, 4'b0000, 32'h80000008, 0, 32'h0,       0, 4'b0000, 0);
        add(0, 3'b000, 0, 32'h0,         1, 4'b0001, 0, 4'b0000, 32'h00000020, 1, 32'h24,      0, 4'b0000, 0);
        add(0, 3'b011, 0, 32'h50,        0, 4'b0001, 0, 4'b0000, 32'h80000004, 0, 32'h0,       0, 4'b0000, 0);
        // edge during a 3-cycle stall, taken on release
        add(1, 3'b000, 0, 32'h0,         0, 4'b0101, 0, 4'b0000, 32'h00000050, 0, 32'h0,       0, 4'b0000, 0);
        add(1, 3'b000, 0, 32'h0,         0, 4'b0101, 0, 4'b0000, 32'h00000050, 0, 32'h0,       0, 4'b0100, 0);
        add(1, 3'b000, 0, 32'h0,         0, 4'b0101, 0, 4'b0000, 32'h00000050, 0, 32'h0,       0, 4'b0100, 0);
        add(0, 3'b000, 0, 32'h0,         0, 4'b0101, 0, 4'b0000, 32'h00000050, 1, 32'h50,      2, 4'b0100, 0);
        // mask cleared, pend held masked, unmasked takes effect next cycle,
        // and a new edge at the clearing edge keeps the bit set
        add(0, 3'b011, 0, 32'h60,        0, 4'b0101, 1, 4'b0000, 32'h80000008, 0, 32'h0,       0, 4'b0000, 0);
        add(0, 3'b000, 0, 32'h0,         0, 4'b0111, 0, 4'b0000, 32'h00000060, 0, 32'h0,       0, 4'b0000, 0);
        add(0, 3'b000, 0, 32'h0,         0, 4'b0101, 1, 4'b0010, 32'h00000064, 0, 32'h0,       0, 4'b0010, 0);
        add(0, 3'b000, 0, 32'h0,         0, 4'b0111, 0, 4'b0000, 32'h00000068, 1, 32'h68,      1, 4'b0010, 0);
        add(0, 3'b011, 0, 32'h80000100,  0, 4'b0111, 0, 4'b0000, 32'h80000008, 0, 32'h0,       0, 4'b0010, 0);
        // kernel-mode illop with a pending interrupt
        add(0, 3'b000, 0, 32'h0,         1, 4'b0111, 0, 4'b0000, 32'h80000100, 0, 32'h0,       0, 4'b0010, 0);
        add(0, 3'b000, 0, 32'h0,         0, 4'b0111, 0, 4'b0000, 32'h80000104, 0, 32'h0,       0, 4'b0010, 1);

        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #2;
            sample($sformatf("row%0d", i));
            @(negedge clk);
        end

        // Reset asserted mid-run between edges: state clears without a clock.
        reset = 1'b1; stall_i = 1'b1; illop_i = 1'b0; pcsrc_i = 3'b000;
        irq_i = 4'b0111; mask_we_i = 1'b0;
        push_exp(32'h0, 0, 32'h0, 0, 4'b0000, 0);
        #2;
        sample("reset_async");
        @(negedge clk);
        stall_i = 1'b0;
        push_exp(32'h0, 0, 32'h0, 0, 4'b0000, 0);
        #2;
        sample("reset_hold");
        @(negedge clk);
        reset = 1'b0;
        push_exp(32'h0, 0, 32'h0, 0, 4'b0000, 0);
        #2;
        sample("reset_release");
        @(negedge clk);
        // Cleared edge history sees the held lines as new edges; mask is all ones.
        push_exp(32'h4, 1, 32'h4, 0, 4'b0111, 0);
        #2;
        sample("post_reset_irq");
        @(negedge clk);
        push_exp(32'h80000008, 0, 32'h0, 0, 4'b0110, 0);
        #2;
        sample("post_reset_vector");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_pc_sequencer.md
IRQ_PC_SEQUENCER -- requirements
Module: irq_pc_sequencer

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- NUM_IRQ, 4, number of interrupt sources (1..16).
- RESET_VEC, 32'h00000000, PC after reset.
- ILLOP_VEC, 32'h80000004, illegal-instruction vector.
- XADR_VEC, 32'h80000008, interrupt vector.
- MASK_RST, all ones, interrupt mask value after reset.

REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, reset; asynchronous, active-high.
- stall_i, in, 1, hold PC; equivalent to if_continue=0.
- pcsrc_i, in, 3, next-PC select: 000 seq, 001 branch, 010 jump, 011 jr.
- branch_taken_i, in, 1, branch condition result.
- branch_tgt_i, in, 32, branch target.
- jidx_i, in, 26, jump index.
- jr_tgt_i, in, 32, register jump target.
- illop_i, in, 1, current instruction is undecodable.
- irq_i, in, NUM_IRQ, level interrupt requests.
- mask_we_i, in, 1, mask register write strobe.
- mask_d_i, in, NUM_IRQ, mask write data.
- pc_o, out, 32, current PC.
- pc4_o, out, 32, {pc_o[31], pc_o[30:0]+4}.
- epc_o, out, 32, return address for the exception-link register.
- epc_we_o, out, 1, write epc_o into register 26 this cycle.
- kernel_o, out, 1, equals pc_o[31].
- pend_o, out, NUM_IRQ, pending interrupt flags.
- irq_id_o, out, 4, index of the interrupt taken this cycle.
- kerr_o, out, 1, sticky flag: illegal instruction seen in kernel mode.

Function
REQ-003 SHALL hold the PC in a 32-bit register updated on the rising edge of clk only when stall_i=0.
REQ-004 SHALL compute the sequential PC as pc4_o: bits [30:0] wrap modulo 2^31; bit 31 never changes.
REQ-005 SHALL select the normal next PC by pcsrc_i:
- 000: pc4_o.
- 001: branch_tgt_i if branch_taken_i=1, else pc4_o.
- 010: {pc_o[31:28], jidx_i, 2'b00}.
- 011: jr_tgt_i.
- other codes: RESET_VEC.
REQ-006 SHALL detect a rising edge on each irq_i bit (synchronised register with previous value, previous value reset to 0) and set the matching pend_o bit, independent of stall_i and of the mask.
REQ-007 SHALL define a taken interrupt as: (pend_o & mask) != 0, kernel_o=0 and stall_i=0.
REQ-008 SHALL, on a taken interrupt:
- load PC with XADR_VEC;
- set epc_o=pc_o (the interrupted instruction is re-executed on return);
- assert epc_we_o for that cycle;
- drive irq_id_o with the lowest set index of (pend_o & mask);
- clear only that pend_o bit at the same edge.
REQ-009 SHALL, when illop_i=1, kernel_o=0, stall_i=0 and no interrupt is taken:
- load PC with ILLOP_VEC;
- set epc_o=pc4_o and assert epc_we_o.
REQ-010 SHALL give an interrupt priority over illop_i in the same cycle.
REQ-011 SHALL, in kernel mode, mask all interrupts and ignore illop_i for PC selection: the normal next PC is used and kerr_o is set, cleared only by reset.
REQ-012 SHALL hold epc_we_o=0 and irq_id_o=0 in every cycle without a taken event, and always while stall_i=1.
REQ-013 SHALL, when mask_we_i=1, load the mask from mask_d_i at the edge; a pend bit newly unmasked takes effect in the following cycle.
REQ-014 SHALL, when an edge and a clear of the same pend bit occur at one edge, leave that bit set.
REQ-015 SHALL leave kernel mode only through a next PC with bit 31 = 0 (jr to a user address); interrupts pending at that point are taken on the first user-mode cycle.
REQ-016 SHALL make all outputs other than registered state purely combinational from current state and inputs (zero-latency decision, one-edge PC update).

Reset
REQ-017 SHALL, on reset assertion, immediately and irrespective of clk, set:
- pc_o=RESET_VEC;
- pend_o=0;
- mask=MASK_RST;
- edge history=0;
- kerr_o=0.
REQ-018 SHALL, while reset is asserted, hold epc_we_o=0 and irq_id_o=0, and take no event.
REQ-019 SHALL discard a sequence in progress (pending or stalled) on reset asserted mid-operation.

Verification
REQ-020 Reset release, pcsrc_i=000 for 3 cycles -> pc_o 0x0, 0x4, 0x8, 0xC.
REQ-021 pc_o=0x7FFFFFFC with pcsrc_i=000 -> next pc_o=0x00000000; pc_o=0xFFFFFFFC -> next 0x80000000.
REQ-022 User mode pc_o=0x40, irq_i=4'b1010 rising edges -> pc_o=0x80000008, epc_o=0x40, epc_we_o=1, irq_id_o=1, pend_o=4'b1000 afterwards. Then jr to 0x40 -> irq 3 taken on the next cycle, epc_o=0x40.
REQ-023 illop_i=1 at pc_o=0x20 with a simultaneous taken irq -> XADR_VEC taken, epc_o=0x20. Retry without the irq -> pc_o=0x80000004, epc_o=0x24.
REQ-024 stall_i=1 for 3 cycles with an irq edge -> pc_o held, epc_we_o=0, pend bit set. Release -> interrupt taken on the first unstalled cycle.
REQ-025 Kernel pc_o=0x80000100 with illop_i=1 and pending irq -> pc_o=0x80000104, kerr_o=1, no epc_we_o. Assert reset mid-run -> pc_o=0x0, kerr_o=0 immediately.
